// File: rtl/umi_pkg.sv
// umi_pkg: shared UMI field offsets, beat sizes, opcodes and unpacker FSM states
package umi_pkg;
  localparam int UMI_HDR_BYTES = 16;
  localparam int UMI_BEAT_BYTES = 32;
  localparam int CMD_LSB = 0;
  localparam int CMD_MSB = 31;
  localparam int DST_LO = 32;
  localparam int SRC_LO = 64;
  localparam int DATA_LO = 96;
  localparam int SRC_HI = 192;
  localparam int DATA_HI = 192;
  localparam int DST_HI = 224;
  localparam logic [7:0] UMI_WRITE_POSTED = 8'h01;
  localparam logic [7:0] UMI_WRITE = 8'h03;
  localparam logic [7:0] UMI_READ = 8'h08;
  typedef enum logic {HDR, BURST} state_t;
endpackage

// File: rtl/umi_burst_count.sv
// umi_burst_count: burst beat count from size, down-counter and final-beat flag
module umi_burst_count
  import umi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] size,
  input  logic       write,
  input  logic       hdr_xfer,
  input  logic       burst_xfer,
  output logic       start,
  output logic       final_beat
);
  logic [10:0] cnt;
  logic [10:0] n;
  assign start = write && size > 4'($clog2(UMI_HDR_BYTES));
  // Beats still owed after the header's 16 bytes, rounded up to whole 32-byte beats
  assign n = 11'(((17'd1 << size) - 17'(UMI_HDR_BYTES) + 17'(UMI_BEAT_BYTES - 1)) >> $clog2(UMI_BEAT_BYTES));
  assign final_beat = cnt == 11'd1;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (hdr_xfer && start) cnt <= n;
    else if (burst_xfer) cnt <= cnt - 11'd1;
endmodule

// File: rtl/umi_decode.sv
// umi_decode: classifies a UMI opcode as read or write request
module umi_decode
  import umi_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       cmd_read,
  output logic       cmd_write
);
  assign cmd_read = opcode == UMI_READ;
  assign cmd_write = opcode == UMI_WRITE || opcode == UMI_WRITE_POSTED;
endmodule

// File: rtl/umi_unpack_rx.sv
// umi_unpack_rx: registered UMI receive unpacker splitting header and burst beats into fields
module umi_unpack_rx
  import umi_pkg::*;
#(
  parameter int AW = 64,
  parameter int PW = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PW-1:0]   packet_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      opcode,
  output logic [3:0]      size,
  output logic [19:0]     user,
  output logic [AW-1:0]   dstaddr,
  output logic [AW-1:0]   srcaddr,
  output logic [4*AW-1:0] data,
  output logic            burst,
  output logic            last
);
  if (AW != 64 || PW != 256) begin : g_bad_param
    $error("umi_unpack_rx supports only AW=64 and PW=256");
  end
  state_t state, state_n;
  logic xfer, hdr_xfer, burst_xfer, cmd_read, cmd_write, start, final_beat, last_n;
  logic [31:0] cmd;
  logic [AW-1:0] dst_n, src_n;
  logic [4*AW-1:0] data_n;
  assign in_ready = ~out_valid | out_ready;
  assign xfer = in_valid & in_ready;
  assign hdr_xfer = xfer && state == HDR;
  assign burst_xfer = xfer && state == BURST;
  assign cmd = packet_in[CMD_MSB:CMD_LSB];
  umi_decode u_decode (
    .opcode(cmd[7:0]),
    .cmd_read(cmd_read),
    .cmd_write(cmd_write)
  );
  umi_burst_count u_count (
    .clk(clk),
    .reset(reset),
    .size(cmd[11:8]),
    .write(cmd_write),
    .hdr_xfer(hdr_xfer),
    .burst_xfer(burst_xfer),
    .start(start),
    .final_beat(final_beat)
  );
  // The previous beat tells whether this is the first burst beat (+16) or a later one (+32)
  always_comb begin
    state_n = hdr_xfer ? (start ? BURST : HDR) : (burst_xfer && final_beat) ? HDR : state;
    dst_n = state == HDR ? {packet_in[PW-1:DST_HI], packet_in[SRC_LO-1:DST_LO]}
                         : dstaddr + (burst ? AW'(UMI_BEAT_BYTES) : AW'(UMI_HDR_BYTES));
    src_n = state != HDR ? '0 : {cmd_read ? packet_in[DST_HI-1:SRC_HI] : 32'h0, packet_in[DATA_LO-1:SRC_LO]};
    data_n = state != HDR ? {packet_in[DATA_LO-1:0], packet_in[PW-1:DATA_LO]}
           : cmd_read ? {160'h0, packet_in[DATA_HI-1:DATA_LO]} : {128'h0, packet_in[DST_HI-1:DATA_LO]};
    last_n = state == HDR ? !start : final_beat;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= HDR;
      out_valid <= 1'b0;
      opcode <= '0;
      size <= '0;
      user <= '0;
      dstaddr <= '0;
      srcaddr <= '0;
      data <= '0;
      burst <= 1'b0;
      last <= 1'b0;
    end else begin
      state <= state_n;
      if (hdr_xfer) {user, size, opcode} <= cmd;
      if (xfer) begin
        out_valid <= 1'b1;
        dstaddr <= dst_n;
        srcaddr <= src_n;
        data <= data_n;
        burst <= state == BURST;
        last <= last_n;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_umi_unpack_rx.sv
// tb_umi_unpack_rx: randomized transaction-level check of the UMI unpacker
module tb_umi_unpack_rx;
  typedef struct packed {
    logic [7:0]   opcode;
    logic [3:0]   size;
    logic [19:0]  user;
    logic [63:0]  dst;
    logic [63:0]  src;
    logic [255:0] data;
    logic         burst;
    logic         last;
  } beat_t;
  logic clk = 1'b0, reset, in_valid, in_ready, out_valid, out_ready, burst, last;
  logic [255:0] packet_in, data;
  logic [7:0] opcode;
  logic [3:0] size;
  logic [19:0] user;
  logic [63:0] dstaddr, srcaddr;
  logic [255:0] pkt_q[$];
  beat_t exp_q[$];
  beat_t cur, snap;
  int n_chk = 0, n_err = 0, n_acc = 0, bubbles = 0;
  bit stall_en, gap_en, nb_en, seen, hold, acc_in;
  umi_unpack_rx #(.AW(64), .PW(256)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .packet_in(packet_in),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .size(size), .user(user),
    .dstaddr(dstaddr), .srcaddr(srcaddr), .data(data), .burst(burst), .last(last)
  );
  always #5 clk = ~clk;
  assign cur = {opcode, size, user, dstaddr, srcaddr, data, burst, last};
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  // Model: header plus ceil((2^size-16)/32) data beats for writes; addresses advance by bytes carried
  task automatic send_txn(input logic [7:0] op, input logic [3:0] sz, input logic [19:0] usr,
                          input logic [63:0] dst, input logic [63:0] src, input logic [127:0] hd);
    logic [255:0] p;
    beat_t e;
    bit rd, wr;
    int rem;
    logic [63:0] a;
    rd = op == 8'h08;
    wr = op == 8'h01 || op == 8'h03;
    p = rand256();
    p[31:0] = {usr, sz, op};
    p[63:32] = dst[31:0];
    p[255:224] = dst[63:32];
    p[95:64] = src[31:0];
    e = '0;
    e.opcode = op; e.size = sz; e.user = usr; e.dst = dst;
    if (rd) begin
      p[223:192] = src[63:32];
      p[191:96] = hd[95:0];
      e.src = src;
      e.data = {160'h0, hd[95:0]};
    end else begin
      p[223:96] = hd;
      e.src = {32'h0, src[31:0]};
      e.data = {128'h0, hd};
    end
    rem = wr ? (1 << sz) - 16 : 0;
    e.last = rem <= 0;
    pkt_q.push_back(p);
    exp_q.push_back(e);
    a = dst + 64'd16;
    while (rem > 0) begin
      p = rand256();
      e.data = (p >> 96) | (p << 160);
      e.burst = 1'b1;
      e.src = '0;
      e.dst = a;
      rem -= 32;
      e.last = rem <= 0;
      pkt_q.push_back(p);
      exp_q.push_back(e);
      a += 64'd32;
    end
  endtask
  task automatic monitor();
    if (hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_beat", cur, snap);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_beat", 1, 0);
      else chk("beat", cur, exp_q.pop_front());
    end
    if (nb_en) begin
      if (out_valid) seen = 1;
      if (seen && exp_q.size() > 0 && !(out_valid && in_ready)) bubbles++;
    end
    hold = out_valid && !out_ready;
    snap = cur;
  endtask
  task automatic cycle();
    @(negedge clk);
    monitor();
    acc_in = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc_in) begin
      void'(pkt_q.pop_front());
      n_acc++;
    end
    in_valid = pkt_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0);
    packet_in = pkt_q.size() > 0 ? pkt_q[0] : rand256();
    out_ready = !stall_en || $urandom_range(0, 2) != 0;
  endtask
  task automatic drain(input int bound);
    int c = 0;
    while ((pkt_q.size() > 0 || exp_q.size() > 0) && c < bound) begin
      cycle();
      c++;
    end
    chk("drain_done", pkt_q.size() + exp_q.size(), 0);
    if (nb_en) chk("bubbles", bubbles, 0);
    bubbles = 0;
    seen = 0;
  endtask
  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; packet_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_burst", burst, 0);
    chk("rst_last", last, 0);
    chk("rst_fields", cur, 0);
    chk("rst_ready", in_ready, 1);
    stall_en = 0; gap_en = 0; nb_en = 1;
    send_txn(8'h01, 4'd3, 20'h12345, 64'h1122_3344_5566_7788, 64'h0000_0000_DEAD_BEEF, {16{8'hA5}});
    drain(50);
    send_txn(8'h08, 4'd2, 20'h00abc, 64'h0000_0000_0000_4000, 64'hCAFE_0000_0000_1000, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677);
    send_txn(8'h03, 4'd0, 20'h00001, 64'h0000_0000_0000_0040, 64'h0, 128'h55);
    drain(50);
    send_txn(8'h03, 4'd6, 20'h0f00f, 64'h0000_1000_0000_2000, 64'h77, rand256());
    drain(50);
    send_txn(8'h03, 4'd15, 20'h7, 64'h0000_0000_8000_0000, 64'h1, rand256());
    drain(5000);
    stall_en = 1; gap_en = 1; nb_en = 0;
    send_txn(8'h01, 4'd7, 20'h5a5a5, 64'h0000_0000_0001_0000, 64'h2, rand256());
    drain(500);
    send_txn(8'h03, 4'd6, 20'h1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h3, rand256());
    drain(100);
    for (int i = 0; i < 30; i++) begin
      logic [7:0] ops [5];
      ops = '{8'h01, 8'h03, 8'h08, 8'h20, 8'h03};
      send_txn(ops[$urandom_range(0, 4)], 4'($urandom_range(0, 9)), 20'($urandom),
               {$urandom, $urandom}, {$urandom, $urandom}, 128'(rand256()));
    end
    drain(20000);
    stall_en = 0; gap_en = 0;
    begin
      int n0, g;
      n0 = n_acc;
      g = 0;
      send_txn(8'h03, 4'd8, 20'h88, 64'h0000_0000_0000_8000, 64'h4, rand256());
      while (n_acc - n0 < 2 && g < 100) begin
        cycle();
        g++;
      end
      chk("rst_test_accepted", n_acc - n0, 2);
    end
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    pkt_q.delete();
    exp_q.delete();
    hold = 0;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_burst", burst, 0);
    chk("midrst_last", last, 0);
    send_txn(8'h03, 4'd3, 20'h99, 64'h0000_0000_0000_9000, 64'h0000_0000_0000_0005, 128'hfeed_face);
    drain(50);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/umi_unpack_rx.md
Name: umi_unpack_rx

Overview:
- Receive-side counterpart of the UMI packer.
- Accepts a 256-bit UMI packet stream with a valid/ready handshake and splits header beats back into opcode, size, user, dstaddr, srcaddr and data.
- Tracks multi-beat write bursts with an internal beat counter and un-rotates the data lanes of each burst beat.
- Sits between the link/FIFO output and the endpoint's request decoder, as one registered pipeline stage.

Parameters:
- AW, 64, address width; only 64 is supported (elaboration error otherwise).
- PW, 256, packet width; only 256 is supported (elaboration error otherwise).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  packet_in is valid
- in_ready  output  1  block accepts packet_in this cycle
- packet_in  input  PW  incoming packet beat
- out_valid  output  1  unpacked fields valid
- out_ready  input  1  downstream accepts this cycle
- opcode  output  8  command opcode (held from header through the burst)
- size  output  4  log2 of total transfer bytes (held)
- user  output  20  user field (held)
- dstaddr  output  AW  byte address of the first data byte carried in this beat
- srcaddr  output  AW  source address (header beats only; 0 on burst beats)
- data  output  4*AW  data lanes, byte 0 at data[7:0]
- burst  output  1  1 = burst data beat, 0 = header beat
- last  output  1  final beat of the transaction

Behaviour:
- Handshake:
  - in_ready = ~out_valid | out_ready.
  - Transfer occurs when in_valid & in_ready.
  - Output register loads on transfer; out_valid clears when out_ready is high and there is no transfer.
  - Latency is 1 cycle; full throughput.
- Reset:
  - out_valid=0, burst=0, last=0; all data/address/command outputs 0.
  - FSM to HDR, counter 0.
  - Reset mid-burst discards remaining burst state; the next accepted beat is treated as a header.
- FSM states:
  - HDR: next beat is a header.
  - BURST: next beat is a data beat.
- Header beat decode (state HDR):
  - cmd = packet_in[31:0]: opcode=[7:0], size=[11:8], user=[31:12].
  - dstaddr = {packet_in[255:224], packet_in[63:32]}.
  - cmd_read and cmd_write come from umi_decode on cmd.
  - cmd_read: srcaddr = {packet_in[223:192], packet_in[95:64]}; data[95:0] = packet_in[191:96]; data[255:96] = 0.
  - Otherwise: srcaddr = {32'h0, packet_in[95:64]}; data[127:0] = packet_in[223:96]; data[255:128] = 0.
  - burst = 0.
- Burst length (writes only):
  - bytes = 2^size; header carries 16 bytes.
  - If cmd_write and size > 4: remaining beats N = (2^size - 16 + 31) >> 5, computed in 11 bits (max 1024 at size=15).
  - Load the counter with N, go to BURST, last=0.
  - Else stay in HDR, last=1.
- Burst beat (state BURST):
  - data[159:0] = packet_in[255:96]; data[255:160] = packet_in[95:0].
  - burst=1; srcaddr=0; opcode/size/user held.
  - dstaddr = previous dstaddr + 16 on the first burst beat, +32 on each later beat. Arithmetic is AW-bit modulo; wrap is allowed, not flagged.
  - Counter decrements per accepted beat. At counter==1: last=1 and go to HDR.
- Stall:
  - While out_valid & ~out_ready, all outputs are held stable and the FSM/counter do not advance.
  - in_valid without in_ready changes nothing.
- Simultaneous out_ready and in_valid: the new beat replaces the old one in the same cycle with no bubble.

Decomposition:
- Package umi_pkg holds:
  - UMI_HDR_BYTES=16 and UMI_BEAT_BYTES=32;
  - field-offset localparams (CMD_LSB/MSB, DST_LO, SRC_LO, DST_HI, SRC_HI/DATA_HI);
  - FSM state typedef {HDR, BURST};
  - opcode constants shared with umi_decode.
- Sub-modules:
  - umi_decode is instantiated for cmd_read/cmd_write.
  - A natural sub-module is umi_burst_count (size→N computation plus down-counter/last generation).
- Everything else stays in the top.

Test Plan:
- Posted write, size=3, dstaddr=64'h1122_3344_5566_7788, data[127:0]=128'hA5…, single beat -> one output cycle later: out_valid=1, burst=0, last=1, fields exactly match; in_ready stays 1.
- Read, size=2, srcaddr=64'hCAFE_0000_0000_1000 -> srcaddr[63:32]=32'hCAFE_0000, data[255:96]=0, last=1; the next beat is decoded as a header.
- Write size=6 (64 B): header plus 2 burst beats -> N=2; dstaddr sequence base, base+16, base+48; lanes un-rotated so data[159:0]=packet[255:96]; last only on the 3rd beat.
- Write size=15 streamed back-to-back with out_ready held at 1 -> 1025 total beats, no bubbles, last on beat 1025, state returns to HDR.
- Random out_ready stalls during a size=7 burst -> outputs stable while stalled, no lost or duplicated beats, order preserved.
- Reset asserted after 1 burst beat of a size=8 write -> out_valid=0 next cycle; the following packet is decoded as a header with correct fields.
